dc_file: RTL and testbench
==========================

# dc_file

Data-controller register file and memory-return stage of core0. It sits directly downstream of the memory controller. It does the following:
- registers the next DC addresses, directions and modify flags each cycle;
- drives the main-memory read and write ports from the controller's request signals;
- tracks in-flight reads through a fixed-latency tag pipeline;
- routes each returned word to the DC value cache, the conveyor or the data stack, forwarding any write that lands on an in-flight read address.

## Interface
Parameters:
- MAIN_ADDR_WIDTH, 32, main memory address width
- WORD_WIDTH, 32, data word width; must be at least MAIN_ADDR_WIDTH
- MEM_LATENCY, 2, memory read latency in cycles (legal range 1..4)

Ports:
- clk  input  1  sole clock
- reset  input  1  asynchronous, active-low; the block is in reset while reset=0
- halt  input  1  freezes architectural state and suppresses new memory requests
- dc_nexts  input  [3:0][MAIN_ADDR_WIDTH]  next DC addresses
- dc_next_directions, dc_next_modifies  input  4 each  next direction and modify flags
- reload  input  1  issue a DC reload read for DC number `choice`
- choice  input  2  DC index for the reload
- conveyor_memload, dstack_memload  input  1 each  issue a conveyor read or a data-stack read
- read_address  input  MAIN_ADDR_WIDTH  address for any issued read
- write_out, write_address, write_value  input  1 / MAIN_ADDR_WIDTH / WORD_WIDTH  write request
- dcs  output  [3:0][MAIN_ADDR_WIDTH]  registered DC addresses
- dc_directions, dc_modifies  output  4 each  registered flags
- dc_vals  output  [3:0][WORD_WIDTH]  cached value at each DC
- dc_val0  output  WORD_WIDTH  equal to dc_vals[0]
- dc_valid  output  4  dc_vals[i] is current
- conveyor_memload_last, dstack_memload_last  output  1 each  registered copies of the corresponding request inputs
- mem_read_en, mem_read_address  output  1 / MAIN_ADDR_WIDTH  memory read port
- mem_write_en, mem_write_address, mem_write_value  output  1 / MAIN_ADDR_WIDTH / WORD_WIDTH  memory write port
- mem_read_data  input  WORD_WIDTH  read data, valid MEM_LATENCY cycles after issue
- conveyor_push, conveyor_data  output  1 / WORD_WIDTH  returned conveyor word
- dstack_push, dstack_data  output  1 / WORD_WIDTH  returned data-stack word

## Operation
Request issue (combinational):
- mem_read_en = !halt & (reload | conveyor_memload | dstack_memload).
- Request priority when more than one is set: reload first, then conveyor, then data stack. Lower-priority requests in the same cycle are dropped.
- mem_read_address = read_address.
- mem_write_en = !halt & write_out; the write address and value pass through unchanged.

Tag pipeline:
- There are MEM_LATENCY stages. Each stage holds: valid, kind (dc / conveyor / dstack), dc index, 2-bit generation id, address, fwd_valid and fwd_value.
- The entry is created at issue and advances every cycle. The pipeline keeps advancing even when halt=1, because memory is not halted.

Write forwarding:
- A write that is issued to the same address as a read issued in the same cycle sets that entry's fwd_valid and fwd_value to the write value.
- A later write to an in-flight entry's address also sets fwd_valid and fwd_value. When several writes hit the same entry, the youngest write wins.

Return (stage MEM_LATENCY):
- The returned data is fwd_value if fwd_valid is set, otherwise mem_read_data.
- conveyor kind: conveyor_push=1 with the returned data.
- dstack kind: dstack_push=1 with the returned data.
- dc kind: the entry writes dc_vals[idx] and sets dc_valid[idx], but only if its generation id equals gen[idx]. Otherwise the return is stale and discarded.

Generations:
- On a reload issue, gen[choice] increments (mod 4), dc_valid[choice] clears, and the entry carries the new gen value.
- No more than 3 reloads to a single DC may be in flight at once, so the 2-bit id cannot alias.

Cache coherence:
- A write issued to address dcs[i] while dc_valid[i]=1 updates dc_vals[i] at the same edge.
- This does not apply to a DC whose reload is issued in that cycle; that DC is handled by forwarding.

Architectural registers, updated every edge with halt=0:
- dcs takes dc_nexts.
- dc_directions and dc_modifies take their next-value inputs.
- The *_memload_last outputs take their request inputs.
- With halt=1, all of these hold.

## Timing
- Reset values: all registered outputs are 0, dc_valid=0, gen=0 and every pipeline valid is 0. The push outputs and mem_*_en are 0 while in reset.
- Reset asserted mid-operation flushes in-flight entries; their returns are never delivered.
- A read issued in cycle t is consumed in cycle t+MEM_LATENCY:
  - push outputs are asserted combinationally in that cycle;
  - dc_vals and dc_valid update at the end of that cycle, so they are visible from t+MEM_LATENCY+1.
- Back-to-back issue every cycle is supported with no bubbles.
- A forwarding write issued in cycle t+MEM_LATENCY (the return cycle) also applies to that return.

## Test plan
- MEM_LATENCY=2: reload with choice=1 at address 0x40, memory returns 0xAA.
  Required: dc_valid[1]=0 in cycles 1-2, then dc_vals[1]=0xAA and dc_valid[1]=1 from cycle 3.
- Reload DC2 to 0x10, then a reload DC2 to 0x20 on the next cycle.
  Required: the first return is discarded and dc_vals[2] ends at the 0x20 data.
- conveyor_memload at 0x8 with a write of 0x55 to 0x8 one cycle later.
  Required: conveyor_push with 0x55, not the memory data.
- reload, conveyor_memload and dstack_memload asserted together.
  Required: only the reload issues; no pushes occur.
- halt=1 with an outstanding dstack read.
  Required: dstack_push still occurs on time, dcs hold, mem_read_en=0.
- reset pulled low one cycle after a reload issue.
  Required: all outputs are 0 and no return is applied after reset is released.

Source files
------------

// File: rtl/dc_file.sv
// DC register file and memory-return stage: issues main-memory reads/writes, tracks reads in a
// fixed-latency tag pipeline and routes each returned word to the DC cache, conveyor or data stack.
module dc_file #(
  parameter int MAIN_ADDR_WIDTH = 32,
  parameter int WORD_WIDTH      = 32,
  parameter int MEM_LATENCY     = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  halt,
  input  logic [3:0][MAIN_ADDR_WIDTH-1:0]       dc_nexts,
  input  logic [3:0]                            dc_next_directions,
  input  logic [3:0]                            dc_next_modifies,
  input  logic                                  reload,
  input  logic [1:0]                            choice,
  input  logic                                  conveyor_memload,
  input  logic                                  dstack_memload,
  input  logic [MAIN_ADDR_WIDTH-1:0]            read_address,
  input  logic                                  write_out,
  input  logic [MAIN_ADDR_WIDTH-1:0]            write_address,
  input  logic [WORD_WIDTH-1:0]                 write_value,
  output logic [3:0][MAIN_ADDR_WIDTH-1:0]       dcs,
  output logic [3:0]                            dc_directions,
  output logic [3:0]                            dc_modifies,
  output logic [3:0][WORD_WIDTH-1:0]            dc_vals,
  output logic [WORD_WIDTH-1:0]                 dc_val0,
  output logic [3:0]                            dc_valid,
  output logic                                  conveyor_memload_last,
  output logic                                  dstack_memload_last,
  output logic                                  mem_read_en,
  output logic [MAIN_ADDR_WIDTH-1:0]            mem_read_address,
  output logic                                  mem_write_en,
  output logic [MAIN_ADDR_WIDTH-1:0]            mem_write_address,
  output logic [WORD_WIDTH-1:0]                 mem_write_value,
  input  logic [WORD_WIDTH-1:0]                 mem_read_data,
  output logic                                  conveyor_push,
  output logic [WORD_WIDTH-1:0]                 conveyor_data,
  output logic                                  dstack_push,
  output logic [WORD_WIDTH-1:0]                 dstack_data
);

  typedef enum logic [1:0] {
    KIND_DC   = 2'd0,
    KIND_CONV = 2'd1,
    KIND_DSTK = 2'd2
  } kind_e;

  typedef struct packed {
    logic                       vld;
    kind_e                      kind;
    logic [1:0]                 idx;
    logic [1:0]                 gen;
    logic [MAIN_ADDR_WIDTH-1:0] addr;
    logic                       fwd_vld;
    logic [WORD_WIDTH-1:0]      fwd_val;
  } tag_t;

  // A write landing on an in-flight read address overrides the memory data; the latest one wins.
  function automatic tag_t fwd_apply(input tag_t t, input logic we,
                                     input logic [MAIN_ADDR_WIDTH-1:0] wa,
                                     input logic [WORD_WIDTH-1:0] wv);
    tag_t r;
    r = t;
    if (t.vld && we && (t.addr == wa)) begin
      r.fwd_vld = 1'b1;
      r.fwd_val = wv;
    end
    return r;
  endfunction

  logic [3:0][MAIN_ADDR_WIDTH-1:0] dcs_q, dcs_d;
  logic [3:0]                      dir_q, dir_d, mod_q, mod_d;
  logic                            conv_last_q, conv_last_d, dstk_last_q, dstk_last_d;
  logic [3:0][WORD_WIDTH-1:0]      vals_q, vals_d;
  logic [3:0]                      valid_q, valid_d;
  logic [3:0][1:0]                 gen_q, gen_d;
  tag_t                            stg_q [MEM_LATENCY];
  tag_t                            stg_d [MEM_LATENCY];
  tag_t                            iss;
  tag_t                            ret;
  logic [WORD_WIDTH-1:0]           ret_dat;
  logic                            rl_iss;
  logic                            ret_ok;

  assign mem_read_en       = reset & ~halt & (reload | conveyor_memload | dstack_memload);
  assign mem_read_address  = read_address;
  assign mem_write_en      = reset & ~halt & write_out;
  assign mem_write_address = write_address;
  assign mem_write_value   = write_value;
  assign rl_iss            = mem_read_en & reload;

  always_comb begin
    iss      = '0;
    iss.vld  = mem_read_en;
    iss.kind = reload ? KIND_DC : (conveyor_memload ? KIND_CONV : KIND_DSTK);
    iss.idx  = choice;
    iss.gen  = gen_q[choice] + 2'd1;
    iss.addr = read_address;
  end

  always_comb begin
    stg_d[0] = fwd_apply(iss, mem_write_en, write_address, write_value);
    for (int k = 1; k < MEM_LATENCY; k++) begin
      stg_d[k] = fwd_apply(stg_q[k-1], mem_write_en, write_address, write_value);
    end
  end

  // The return stage also sees a write issued in the return cycle itself.
  always_comb begin
    ret     = fwd_apply(stg_q[MEM_LATENCY-1], mem_write_en, write_address, write_value);
    ret_dat = ret.fwd_vld ? ret.fwd_val : mem_read_data;
  end

  assign conveyor_push = ret.vld && (ret.kind == KIND_CONV);
  assign dstack_push   = ret.vld && (ret.kind == KIND_DSTK);
  assign conveyor_data = conveyor_push ? ret_dat : '0;
  assign dstack_data   = dstack_push ? ret_dat : '0;

  // A reload issued this cycle supersedes both a return and a coherent write to the same DC.
  always_comb begin
    gen_d   = gen_q;
    vals_d  = vals_q;
    valid_d = valid_q;
    ret_ok  = ret.vld && (ret.kind == KIND_DC) && (ret.gen == gen_q[ret.idx]) &&
              !(rl_iss && (choice == ret.idx));
    if (ret_ok) begin
      vals_d[ret.idx]  = ret_dat;
      valid_d[ret.idx] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (mem_write_en && (write_address == dcs_q[i]) && valid_q[i] &&
          !(rl_iss && (choice == 2'(i)))) begin
        vals_d[i] = write_value;
      end
    end
    if (rl_iss) begin
      gen_d[choice]   = gen_q[choice] + 2'd1;
      valid_d[choice] = 1'b0;
    end
  end

  always_comb begin
    dcs_d       = halt ? dcs_q : dc_nexts;
    dir_d       = halt ? dir_q : dc_next_directions;
    mod_d       = halt ? mod_q : dc_next_modifies;
    conv_last_d = halt ? conv_last_q : conveyor_memload;
    dstk_last_d = halt ? dstk_last_q : dstack_memload;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcs_q       <= '0;
      dir_q       <= '0;
      mod_q       <= '0;
      conv_last_q <= 1'b0;
      dstk_last_q <= 1'b0;
      vals_q      <= '0;
      valid_q     <= '0;
      gen_q       <= '0;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      dcs_q       <= dcs_d;
      dir_q       <= dir_d;
      mod_q       <= mod_d;
      conv_last_q <= conv_last_d;
      dstk_last_q <= dstk_last_d;
      vals_q      <= vals_d;
      valid_q     <= valid_d;
      gen_q       <= gen_d;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  assign dcs                   = dcs_q;
  assign dc_directions         = dir_q;
  assign dc_modifies           = mod_q;
  assign dc_vals               = vals_q;
  assign dc_val0               = vals_q[0];
  assign dc_valid              = valid_q;
  assign conveyor_memload_last = conv_last_q;
  assign dstack_memload_last   = dstk_last_q;

endmodule

// File: tb/tb_dc_file.sv
// Directed vector bench for dc_file at MEM_LATENCY=2; one vector per clock cycle.
module tb_dc_file;

  logic              clk = 1'b0;
  logic              reset;
  logic              halt;
  logic [3:0][31:0]  dc_nexts;
  logic [3:0]        dc_next_directions, dc_next_modifies;
  logic              reload;
  logic [1:0]        choice;
  logic              conveyor_memload, dstack_memload;
  logic [31:0]       read_address;
  logic              write_out;
  logic [31:0]       write_address, write_value;
  logic [3:0][31:0]  dcs;
  logic [3:0]        dc_directions, dc_modifies;
  logic [3:0][31:0]  dc_vals;
  logic [31:0]       dc_val0;
  logic [3:0]        dc_valid;
  logic              conveyor_memload_last, dstack_memload_last;
  logic              mem_read_en;
  logic [31:0]       mem_read_address;
  logic              mem_write_en;
  logic [31:0]       mem_write_address, mem_write_value;
  logic [31:0]       mem_read_data;
  logic              conveyor_push, dstack_push;
  logic [31:0]       conveyor_data, dstack_data;

  dc_file #(.MAIN_ADDR_WIDTH(32), .WORD_WIDTH(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .dc_nexts(dc_nexts), .dc_next_directions(dc_next_directions), .dc_next_modifies(dc_next_modifies),
    .reload(reload), .choice(choice), .conveyor_memload(conveyor_memload), .dstack_memload(dstack_memload),
    .read_address(read_address), .write_out(write_out), .write_address(write_address), .write_value(write_value),
    .dcs(dcs), .dc_directions(dc_directions), .dc_modifies(dc_modifies), .dc_vals(dc_vals), .dc_val0(dc_val0),
    .dc_valid(dc_valid), .conveyor_memload_last(conveyor_memload_last), .dstack_memload_last(dstack_memload_last),
    .mem_read_en(mem_read_en), .mem_read_address(mem_read_address), .mem_write_en(mem_write_en),
    .mem_write_address(mem_write_address), .mem_write_value(mem_write_value), .mem_read_data(mem_read_data),
    .conveyor_push(conveyor_push), .conveyor_data(conveyor_data),
    .dstack_push(dstack_push), .dstack_data(dstack_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, hlt, rl;
    logic [1:0]  ch;
    logic        cv, ds;
    logic [31:0] ra;
    logic        wr;
    logic [31:0] wa, wv, md, dn;
    logic        rd, cp;
    logic [31:0] cd;
    logic        dp;
    logic [31:0] dd;
    logic [3:0]  vl;
    logic [31:0] v1, v2, d0;
    logic        dl;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  int n_cmp  = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, hlt, rl, input logic [1:0] ch, input logic cv, ds, input logic [31:0] ra,
    input logic wr, input logic [31:0] wa, wv, md, dn,
    input logic rd, cp, input logic [31:0] cd, input logic dp, input logic [31:0] dd,
    input logic [3:0] vl, input logic [31:0] v1, v2, d0, input logic dl);
    vec_t v;
    v.rst = rst; v.hlt = hlt; v.rl = rl; v.ch = ch; v.cv = cv; v.ds = ds; v.ra = ra;
    v.wr = wr; v.wa = wa; v.wv = wv; v.md = md; v.dn = dn;
    v.rd = rd; v.cp = cp; v.cd = cd; v.dp = dp; v.dd = dd;
    v.vl = vl; v.v1 = v1; v.v2 = v2; v.d0 = d0; v.dl = dl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at vector %0d: got %h, want %h", nm, n_vec, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    reset            = v.rst;
    halt             = v.hlt;
    reload           = v.rl;
    choice           = v.ch;
    conveyor_memload = v.cv;
    dstack_memload   = v.ds;
    read_address     = v.ra;
    write_out        = v.wr;
    write_address    = v.wa;
    write_value      = v.wv;
    mem_read_data    = v.md;
    for (int i = 0; i < 4; i++) dc_nexts[i] = v.dn + 32'(i);
    dc_next_directions = v.dn[3:0];
    dc_next_modifies   = ~v.dn[3:0];
    #4;
    chk("mem_read_en", 32'(mem_read_en), 32'(v.rd));
    chk("conveyor_push", 32'(conveyor_push), 32'(v.cp));
    if (v.cp) chk("conveyor_data", conveyor_data, v.cd);
    chk("dstack_push", 32'(dstack_push), 32'(v.dp));
    if (v.dp) chk("dstack_data", dstack_data, v.dd);
    chk("dc_valid", 32'(dc_valid), 32'(v.vl));
    chk("dc_vals1", dc_vals[1], v.v1);
    chk("dc_vals2", dc_vals[2], v.v2);
    chk("dcs0", dcs[0], v.d0);
    chk("dstack_memload_last", 32'(dstack_memload_last), 32'(v.dl));
    n_vec++;
  endtask

  initial begin
    reset = 1'b0; halt = 1'b0; reload = 1'b0; choice = 2'd0;
    conveyor_memload = 1'b0; dstack_memload = 1'b0; read_address = '0;
    write_out = 1'b0; write_address = '0; write_value = '0; mem_read_data = '0;
    dc_nexts = '0; dc_next_directions = '0; dc_next_modifies = '0;

    //            rst hlt rl ch cv ds ra       wr wa       wv       md       dn          rd cp cd      dp dd      vl    v1       v2       d0       dl
    // reset and release; a request during reset must not issue
    tbl.push_back(mk(0,0,1,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'h0,32'h0,   32'h0,   32'h0,   0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'h0,32'h0,   32'h0,   32'h0,   0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'h0,32'h0,   32'h0,   32'h0,   0));
    // reload DC1 @0x40, data 0xAA returns in cycle +2, visible in cycle +3
    tbl.push_back(mk(1,0,1,1,0,0,32'h40,   0,32'h0,  32'h0,   32'h0,   32'h100,    1,0,32'h0,  0,32'h0,  4'h0,32'h0,   32'h0,   32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'h0,32'h0,   32'h0,   32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'hAA,  32'h100,    0,0,32'h0,  0,32'h0,  4'h0,32'h0,   32'h0,   32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'h2,32'hAA,  32'h0,   32'h100, 0));
    // two back-to-back reloads of DC2: first return is stale
    tbl.push_back(mk(1,0,1,2,0,0,32'h10,   0,32'h0,  32'h0,   32'h0,   32'h100,    1,0,32'h0,  0,32'h0,  4'h2,32'hAA,  32'h0,   32'h100, 0));
    tbl.push_back(mk(1,0,1,2,0,0,32'h20,   0,32'h0,  32'h0,   32'h0,   32'h100,    1,0,32'h0,  0,32'h0,  4'h2,32'hAA,  32'h0,   32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h1111,32'h100,    0,0,32'h0,  0,32'h0,  4'h2,32'hAA,  32'h0,   32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h2222,32'h100,    0,0,32'h0,  0,32'h0,  4'h2,32'hAA,  32'h0,   32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'h6,32'hAA,  32'h2222,32'h100, 0));
    // conveyor read @0x8, write 0x55 to 0x8 one cycle later is forwarded
    tbl.push_back(mk(1,0,0,0,1,0,32'h8,    0,32'h0,  32'h0,   32'h0,   32'h100,    1,0,32'h0,  0,32'h0,  4'h6,32'hAA,  32'h2222,32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    1,32'h8,  32'h55,  32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'h6,32'hAA,  32'h2222,32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'hDEAD,32'h100,    0,1,32'h55, 0,32'h0,  4'h6,32'hAA,  32'h2222,32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'h6,32'hAA,  32'h2222,32'h100, 0));
    // all three requests together: only the reload (DC3) issues
    tbl.push_back(mk(1,0,1,3,1,1,32'h30,   0,32'h0,  32'h0,   32'h0,   32'h100,    1,0,32'h0,  0,32'h0,  4'h6,32'hAA,  32'h2222,32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'h6,32'hAA,  32'h2222,32'h100, 1));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h3333,32'h100,    0,0,32'h0,  0,32'h0,  4'h6,32'hAA,  32'h2222,32'h100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h100,    0,0,32'h0,  0,32'h0,  4'hE,32'hAA,  32'h2222,32'h100, 0));
    // halt with an outstanding dstack read
    tbl.push_back(mk(1,0,0,0,0,1,32'h50,   0,32'h0,  32'h0,   32'h0,   32'h200,    1,0,32'h0,  0,32'h0,  4'hE,32'hAA,  32'h2222,32'h100, 0));
    tbl.push_back(mk(1,1,0,0,0,1,32'h54,   0,32'h0,  32'h0,   32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'hE,32'hAA,  32'h2222,32'h200, 1));
    tbl.push_back(mk(1,1,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h7777,32'h300,    0,0,32'h0,  1,32'h7777,4'hE,32'hAA,  32'h2222,32'h200, 1));
    tbl.push_back(mk(1,1,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'hE,32'hAA,  32'h2222,32'h200, 1));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'hE,32'hAA,  32'h2222,32'h200, 1));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'hE,32'hAA,  32'h2222,32'h300, 0));
    // coherent write to dcs[1]=0x301 while valid
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    1,32'h301,32'hBEEF,32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'hE,32'hAA,  32'h2222,32'h300, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 0));
    // write in the return cycle forwards into that return
    tbl.push_back(mk(1,0,0,0,0,1,32'h60,   0,32'h0,  32'h0,   32'h0,   32'h300,    1,0,32'h0,  0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 1));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    1,32'h60, 32'h6666,32'h1234,32'h300,    0,0,32'h0,  1,32'h6666,4'hE,32'hBEEF,32'h2222,32'h300, 0));
    // back-to-back conveyor then dstack
    tbl.push_back(mk(1,0,0,0,1,0,32'h70,   0,32'h0,  32'h0,   32'h0,   32'h300,    1,0,32'h0,  0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 0));
    tbl.push_back(mk(1,0,0,0,0,1,32'h74,   0,32'h0,  32'h0,   32'h0,   32'h300,    1,0,32'h0,  0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'hA1,  32'h300,    0,1,32'hA1, 0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 1));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'hA2,  32'h300,    0,0,32'h0,  1,32'hA2, 4'hE,32'hBEEF,32'h2222,32'h300, 0));
    // same-cycle write then a younger write: youngest wins
    tbl.push_back(mk(1,0,0,0,1,0,32'h80,   1,32'h80, 32'h11,  32'h0,   32'h300,    1,0,32'h0,  0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    1,32'h80, 32'h22,  32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h99,  32'h300,    0,1,32'h22, 0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 0));
    // reset one cycle after a reload issue flushes it
    tbl.push_back(mk(1,0,1,0,0,0,32'h90,   0,32'h0,  32'h0,   32'h0,   32'h300,    1,0,32'h0,  0,32'h0,  4'hE,32'hBEEF,32'h2222,32'h300, 0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'h0,32'h0,   32'h0,   32'h0,   0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'hCC,  32'h300,    0,0,32'h0,  0,32'h0,  4'h0,32'h0,   32'h0,   32'h0,   0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,    0,32'h0,  32'h0,   32'h0,   32'h300,    0,0,32'h0,  0,32'h0,  4'h0,32'h0,   32'h0,   32'h300, 0));

    for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k]);

    // Three reloads of DC1 in flight: only the last (0xB2) is kept.
    run_vec(mk(1,0,1,1,0,0,32'hA0, 0,32'h0,32'h0, 32'h0, 32'h300, 1,0,32'h0,0,32'h0, 4'h0,32'h0, 32'h0,32'h300,0));
    run_vec(mk(1,0,1,1,0,0,32'hA4, 0,32'h0,32'h0, 32'h0, 32'h300, 1,0,32'h0,0,32'h0, 4'h0,32'h0, 32'h0,32'h300,0));
    run_vec(mk(1,0,1,1,0,0,32'hA8, 0,32'h0,32'h0, 32'hB0,32'h300, 1,0,32'h0,0,32'h0, 4'h0,32'h0, 32'h0,32'h300,0));
    run_vec(mk(1,0,0,0,0,0,32'h0,  0,32'h0,32'h0, 32'hB1,32'h300, 0,0,32'h0,0,32'h0, 4'h0,32'h0, 32'h0,32'h300,0));
    run_vec(mk(1,0,0,0,0,0,32'h0,  0,32'h0,32'h0, 32'hB2,32'h300, 0,0,32'h0,0,32'h0, 4'h0,32'h0, 32'h0,32'h300,0));
    run_vec(mk(1,0,0,0,0,0,32'h0,  0,32'h0,32'h0, 32'h0, 32'h300, 0,0,32'h0,0,32'h0, 4'h2,32'hB2,32'h0,32'h300,0));
    // Reload DC1 plus a write to dcs[1] in the same cycle: no coherent update, write is forwarded.
    run_vec(mk(1,0,1,1,0,0,32'h301,1,32'h301,32'hC0,32'h0,32'h300, 1,0,32'h0,0,32'h0, 4'h2,32'hB2,32'h0,32'h300,0));
    run_vec(mk(1,0,0,0,0,0,32'h0,  0,32'h0,32'h0, 32'h0, 32'h300, 0,0,32'h0,0,32'h0, 4'h0,32'hB2,32'h0,32'h300,0));
    run_vec(mk(1,0,0,0,0,0,32'h0,  0,32'h0,32'h0, 32'hDD,32'h300, 0,0,32'h0,0,32'h0, 4'h0,32'hB2,32'h0,32'h300,0));
    run_vec(mk(1,0,0,0,0,0,32'h0,  0,32'h0,32'h0, 32'h0, 32'h300, 0,0,32'h0,0,32'h0, 4'h2,32'hC0,32'h0,32'h300,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
